// File: rtl/conv_scheduler.sv
// Frame scheduler for the convolution engine: sequences LOAD/PROC/READ per block,
// hands address-generator handshakes through, and guards PROC with a watchdog.
module conv_scheduler #(
    parameter int NB_IMAGE = 10,
    parameter int NB_BLOCK = 4,
    parameter int TIMEOUT  = 2048
) (
    input  logic                i_CLK,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic                i_abort,
    input  logic [NB_BLOCK-1:0] i_nBlocks,
    input  logic [NB_IMAGE-1:0] i_imgLength,
    input  logic                i_hostValid,
    input  logic                i_EoP,
    input  logic                i_changeBlock,
    output logic                o_SoP,
    output logic                o_agValid,
    output logic [NB_IMAGE-1:0] o_imgLength,
    output logic [1:0]          o_phase,
    output logic [NB_BLOCK-1:0] o_blockIdx,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_error
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        PROC = 2'b10,
        READ = 2'b11
    } state_t;

    state_t              state_r;
    logic                sop_r;
    logic                busy_r;
    logic                done_r;
    logic                error_r;
    logic [NB_BLOCK-1:0] blk_r;
    logic [NB_BLOCK-1:0] nblk_r;
    logic [NB_IMAGE-1:0] img_r;
    logic [WD_W-1:0]     wdog_r;
    logic                ag_valid_s;

    // Frame state machine with registered status outputs; abort outranks everything but reset
    always_ff @(posedge i_CLK or posedge i_reset) begin
        if (i_reset) begin
            state_r <= IDLE;
            sop_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            error_r <= 1'b0;
            blk_r   <= {NB_BLOCK{1'b0}};
            nblk_r  <= {NB_BLOCK{1'b0}};
            img_r   <= {NB_IMAGE{1'b0}};
            wdog_r  <= {WD_W{1'b0}};
        end else if (i_abort) begin
            state_r <= IDLE;
            sop_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            wdog_r  <= {WD_W{1'b0}};
        end else begin
            sop_r  <= 1'b0;
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (i_start && (i_nBlocks != {NB_BLOCK{1'b0}})) begin
                        state_r <= LOAD;
                        busy_r  <= 1'b1;
                        nblk_r  <= i_nBlocks;
                        img_r   <= i_imgLength;
                        blk_r   <= {NB_BLOCK{1'b0}};
                        error_r <= 1'b0;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LOAD: begin
                    if (i_changeBlock) begin
                        state_r <= PROC;
                        sop_r   <= 1'b1;
                        wdog_r  <= {WD_W{1'b0}};
                    end else begin
                        state_r <= LOAD;
                    end
                end
                PROC: begin
                    // End-of-process beats a watchdog expiry landing on the same cycle
                    if (i_EoP) begin
                        state_r <= READ;
                    end else if (wdog_r == WD_W'(TIMEOUT - 1)) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        error_r <= 1'b1;
                    end else begin
                        wdog_r <= wdog_r + WD_W'(1);
                    end
                end
                READ: begin
                    if (i_changeBlock) begin
                        if (blk_r == (nblk_r - NB_BLOCK'(1))) begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= LOAD;
                            blk_r   <= blk_r + NB_BLOCK'(1);
                        end
                    end else begin
                        state_r <= READ;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Host valid reaches the address generator only while loading or reading out
    always_comb begin
        ag_valid_s = 1'b0;
        if ((state_r == LOAD) || (state_r == READ)) begin
            ag_valid_s = i_hostValid;
        end else begin
            ag_valid_s = 1'b0;
        end
    end

    assign o_SoP       = sop_r;
    assign o_agValid   = ag_valid_s;
    assign o_imgLength = img_r;
    assign o_phase     = state_r;
    assign o_blockIdx  = blk_r;
    assign o_busy      = busy_r;
    assign o_done      = done_r;
    assign o_error     = error_r;

endmodule

// File: tb/tb_conv_scheduler.sv
// Directed bench for conv_scheduler: frame flow, zero-block start, watchdog, abort and reset.
module tb_conv_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [3:0] n_blocks;
    logic [9:0] img_len;
    logic       host_valid;
    logic       eop;
    logic       change_block;
    logic       sop;
    logic       ag_valid;
    logic [9:0] img_out;
    logic [1:0] phase;
    logic [3:0] blk_idx;
    logic       busy;
    logic       done;
    logic       error;

    int checks   = 0;
    int failures = 0;
    int sop_cnt  = 0;
    int done_cnt = 0;

    conv_scheduler dut (
        .i_CLK         (clk),
        .i_reset       (rst),
        .i_start       (start),
        .i_abort       (abort),
        .i_nBlocks     (n_blocks),
        .i_imgLength   (img_len),
        .i_hostValid   (host_valid),
        .i_EoP         (eop),
        .i_changeBlock (change_block),
        .o_SoP         (sop),
        .o_agValid     (ag_valid),
        .o_imgLength   (img_out),
        .o_phase       (phase),
        .o_blockIdx    (blk_idx),
        .o_busy        (busy),
        .o_done        (done),
        .o_error       (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sop === 1'b1) sop_cnt = sop_cnt + 1;
        if (done === 1'b1) done_cnt = done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Start a frame from IDLE and take it through LOAD into PROC
    task automatic start_to_proc(input logic [3:0] nb, input logic [9:0] len);
        start = 1'b1; n_blocks = nb; img_len = len;
        cyc(1);
        start = 1'b0;
        change_block = 1'b1;
        cyc(1);
        change_block = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; n_blocks = 4'd0; img_len = 10'd0;
        host_valid = 1'b0; eop = 1'b0; change_block = 1'b0;
        #3;
        chk("rst_phase", 32'(phase), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_outs", {26'd0, sop, ag_valid, done, error, 2'd0}, 32'd0);
        chk("rst_img_blk", {18'd0, img_out, blk_idx}, 32'd0);
        cyc(2);
        rst = 1'b0;
        cyc(1);

        // Two-block frame
        start = 1'b1; n_blocks = 4'd2; img_len = 10'd300;
        cyc(1);
        start = 1'b0; n_blocks = 4'd7; img_len = 10'd5;
        chk("f_load_phase", 32'(phase), 32'd1);
        chk("f_load_busy", 32'(busy), 32'd1);
        chk("f_img_latched", 32'(img_out), 32'd300);
        host_valid = 1'b1; #1;
        chk("f_agv_load_hi", 32'(ag_valid), 32'd1);
        host_valid = 1'b0; #1;
        chk("f_agv_load_lo", 32'(ag_valid), 32'd0);
        eop = 1'b1; start = 1'b1;
        cyc(1);
        eop = 1'b0; start = 1'b0;
        chk("f_eop_in_load", 32'(phase), 32'd1);
        chk("f_start_in_load_img", 32'(img_out), 32'd300);
        change_block = 1'b1; host_valid = 1'b1;
        cyc(1);
        change_block = 1'b0;
        chk("f_proc_phase", 32'(phase), 32'd2);
        chk("f_sop_first", 32'(sop), 32'd1);
        chk("f_agv_proc", 32'(ag_valid), 32'd0);
        change_block = 1'b1;
        cyc(1);
        change_block = 1'b0; host_valid = 1'b0;
        chk("f_sop_second", 32'(sop), 32'd0);
        chk("f_cb_in_proc", 32'(phase), 32'd2);
        cyc(1027);
        eop = 1'b1;
        cyc(1);
        eop = 1'b0;
        chk("f_read_phase", 32'(phase), 32'd3);
        host_valid = 1'b1; #1;
        chk("f_agv_read", 32'(ag_valid), 32'd1);
        host_valid = 1'b0;
        change_block = 1'b1;
        cyc(1);
        change_block = 1'b0;
        chk("f_load2_phase", 32'(phase), 32'd1);
        chk("f_blk1", 32'(blk_idx), 32'd1);
        chk("f_no_done_mid", 32'(done), 32'd0);
        change_block = 1'b1;
        cyc(1);
        change_block = 1'b0;
        chk("f_sop_blk1", 32'(sop), 32'd1);
        cyc(1029);
        eop = 1'b1;
        cyc(1);
        eop = 1'b0;
        chk("f_read2_phase", 32'(phase), 32'd3);
        change_block = 1'b1;
        cyc(1);
        change_block = 1'b0;
        chk("f_end_phase", 32'(phase), 32'd0);
        chk("f_done", 32'(done), 32'd1);
        chk("f_end_busy", 32'(busy), 32'd0);
        cyc(1);
        chk("f_done_pulse", 32'(done), 32'd0);
        chk("f_blk_hold", 32'(blk_idx), 32'd1);
        chk("f_sop_count", 32'(sop_cnt), 32'd2);
        chk("f_done_count", 32'(done_cnt), 32'd1);

        // Zero-block start is ignored
        start = 1'b1; n_blocks = 4'd0; img_len = 10'd5;
        cyc(1);
        start = 1'b0;
        chk("z_busy", 32'(busy), 32'd0);
        chk("z_done_err", {30'd0, done, error}, 32'd0);
        chk("z_img_kept", 32'(img_out), 32'd300);

        // Watchdog expiry with no end-of-process
        start_to_proc(4'd1, 10'd7);
        cyc(2047);
        chk("w_still_proc", 32'(phase), 32'd2);
        cyc(1);
        chk("w_idle", 32'(phase), 32'd0);
        chk("w_error", 32'(error), 32'd1);
        chk("w_no_done", 32'(done), 32'd0);
        abort = 1'b1;
        cyc(3);
        abort = 1'b0;
        chk("w_error_sticky", 32'(error), 32'd1);
        start = 1'b1; n_blocks = 4'd1;
        cyc(1);
        start = 1'b0;
        chk("w_error_clear", 32'(error), 32'd0);
        chk("w_restart_phase", 32'(phase), 32'd1);

        // End-of-process on the expiry cycle wins
        change_block = 1'b1;
        cyc(1);
        change_block = 1'b0;
        cyc(2047);
        eop = 1'b1;
        cyc(1);
        eop = 1'b0;
        chk("e_read", 32'(phase), 32'd3);
        chk("e_no_error", 32'(error), 32'd0);
        change_block = 1'b1;
        cyc(1);
        change_block = 1'b0;
        chk("e_done_single", 32'(done), 32'd1);

        // Abort coincident with the final block change
        start_to_proc(4'd1, 10'd8);
        eop = 1'b1;
        cyc(1);
        eop = 1'b0;
        change_block = 1'b1; abort = 1'b1;
        cyc(1);
        change_block = 1'b0; abort = 1'b0;
        chk("a_phase", 32'(phase), 32'd0);
        chk("a_no_done", 32'(done), 32'd0);
        cyc(1);
        chk("a_done_count", 32'(done_cnt), 32'd2);

        // Asynchronous reset in the middle of PROC
        start_to_proc(4'd3, 10'd9);
        cyc(5);
        host_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("r_phase", 32'(phase), 32'd0);
        chk("r_outs", {26'd0, sop, ag_valid, done, error, busy, 1'b0}, 32'd0);
        chk("r_img_blk", {18'd0, img_out, blk_idx}, 32'd0);
        #1;
        rst = 1'b0; host_valid = 1'b0;
        cyc(3);
        chk("r_stay_idle", 32'(phase), 32'd0);
        chk("r_done_count", 32'(done_cnt), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
